// File: rtl/key_pkg.sv
// Shared types and constants for the key event tracker.
// Build option: KEY_EVENT_TRACKER_MOVE_FILTER_EN restricts keycode to the WASD movement keys.
package key_pkg;

   localparam logic [7:0] KEY_NONE = 8'h00;
   localparam logic [7:0] KEY_A    = 8'h04;
   localparam logic [7:0] KEY_D    = 8'h07;
   localparam logic [7:0] KEY_S    = 8'h16;
   localparam logic [7:0] KEY_W    = 8'h1A;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StApply
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [7:0] code;
   } slot_t;

   // Decides whether a held code may drive the movement keycode output.
   function automatic logic is_move_eligible(input logic [7:0] code);
`ifdef KEY_EVENT_TRACKER_MOVE_FILTER_EN
      return (code == KEY_A) || (code == KEY_D) || (code == KEY_S) || (code == KEY_W);
`else
      return (code != KEY_NONE);
`endif
   endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Single-clock event queue; full blocks pushes even when a pop happens in the same cycle.
module key_event_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 9
) (
   input  logic             frame_clk,
   input  logic             Reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr_q];

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge frame_clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push_ok && !pop_ok)      count_q <= count_q + (AW+1)'(1);
         else if (pop_ok && !push_ok) count_q <= count_q - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/key_event_tracker.sv
// Tracks held keys in a most-recent-first table and reports the current movement key.
// Build option: KEY_EVENT_TRACKER_MOVE_FILTER_EN (see key_pkg::is_move_eligible).
module key_event_tracker #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SLOTS      = 4
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [7:0] ev_code,
   input  logic       ev_press,
   output logic [7:0] keycode,
   output logic [2:0] held_count,
   output logic       overflow,
   output logic       busy
);

   import key_pkg::*;

   localparam int unsigned IdxW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   state_t          state_q, state_d;
   logic            pop;
   logic [8:0]      fifo_rdata;
   logic            fifo_full;
   logic            fifo_empty;

   logic [7:0]      ev_code_q;
   logic            ev_press_q;
   logic            hit_q;
   logic [IdxW-1:0] hit_idx_q;
   logic            scan_hit;
   logic [IdxW-1:0] scan_idx;

   slot_t           slots_q [SLOTS];
   slot_t           slots_d [SLOTS];
   logic            overflow_q, overflow_d;
   logic [7:0]      keycode_q, keycode_d;
   logic [2:0]      held_q, held_d;

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .push      (ev_valid && ev_ready),
      .pop       (pop),
      .wdata     ({ev_code, ev_press}),
      .rdata     (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign ev_ready   = !fifo_full;
   assign busy       = (state_q != StIdle) || !fifo_empty;
   assign keycode    = keycode_q;
   assign held_count = held_q;
   assign overflow   = overflow_q;

   // FSM state register.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state: one event per IDLE->SCAN->APPLY pass.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = StScan;
            end
         end
         StScan:  state_d = StApply;
         StApply: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Parallel match of the latched code against every valid slot; first match wins.
   always_comb begin
      scan_hit = 1'b0;
      scan_idx = '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
         if (!scan_hit && slots_q[i].valid && (slots_q[i].code == ev_code_q)) begin
            scan_hit = 1'b1;
            scan_idx = IdxW'(i);
         end
      end
   end

   // Latch the popped event, then the scan result.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         ev_code_q  <= KEY_NONE;
         ev_press_q <= 1'b0;
         hit_q      <= 1'b0;
         hit_idx_q  <= '0;
      end else begin
         if (pop) {ev_code_q, ev_press_q} <= fifo_rdata;
         if (state_q == StScan) begin
            hit_q     <= scan_hit;
            hit_idx_q <= scan_idx;
         end
      end
   end

   // Table update in APPLY; code 00 never touches the table.
   always_comb begin
      slots_d    = slots_q;
      overflow_d = overflow_q;
      if ((state_q == StApply) && (ev_code_q != KEY_NONE)) begin
         if (ev_press_q) begin
            if (hit_q) begin
               // Rotate the matched slot to the front, keep others in order.
               for (int i = 1; i < int'(SLOTS); i++) begin
                  if (i <= int'(hit_idx_q)) slots_d[i] = slots_q[i-1];
               end
               slots_d[0] = slots_q[hit_idx_q];
            end else begin
               for (int i = 1; i < int'(SLOTS); i++) begin
                  slots_d[i] = slots_q[i-1];
               end
               slots_d[0] = {1'b1, ev_code_q};
               if (slots_q[SLOTS-1].valid) overflow_d = 1'b1;
            end
         end else if (hit_q) begin
            // Close the gap left by the released key.
            for (int i = 0; i < int'(SLOTS) - 1; i++) begin
               if (i >= int'(hit_idx_q)) slots_d[i] = slots_q[i+1];
            end
            slots_d[SLOTS-1] = '0;
         end
      end
   end

   // Derive keycode and held count from the next table image.
   always_comb begin
      int unsigned cnt;
      keycode_d = KEY_NONE;
      cnt       = 0;
      for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
         if (slots_d[i].valid) begin
            cnt = cnt + 1;
            if (is_move_eligible(slots_d[i].code)) keycode_d = slots_d[i].code;
         end
      end
      held_d = 3'(cnt);
   end

   // Table and output registers; only change on the APPLY edge.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < int'(SLOTS); i++) slots_q[i] <= '0;
         overflow_q <= 1'b0;
         keycode_q  <= KEY_NONE;
         held_q     <= '0;
      end else begin
         slots_q    <= slots_d;
         overflow_q <= overflow_d;
         keycode_q  <= keycode_d;
         held_q     <= held_d;
      end
   end

endmodule

// File: tb/tb_key_event_tracker.sv
// Scoreboard bench for key_event_tracker: a list-based held-key model predicts each applied event.
module tb_key_event_tracker;

   logic       frame_clk = 1'b0;
   logic       Reset     = 1'b1;
   logic       ev_valid  = 1'b0;
   logic       ev_ready;
   logic [7:0] ev_code   = 8'h00;
   logic       ev_press  = 1'b0;
   logic [7:0] keycode;
   logic [2:0] held_count;
   logic       overflow;
   logic       busy;

   key_event_tracker #(
      .FIFO_DEPTH (4),
      .SLOTS      (4)
   ) dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_code    (ev_code),
      .ev_press   (ev_press),
      .keycode    (keycode),
      .held_count (held_count),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 frame_clk = ~frame_clk;

   typedef struct {
      int         due;
      logic [7:0] kc;
      logic [2:0] hc;
      logic       ov;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] held[$];
   logic       model_ov;
   int         cyc;
   int         last_due;
   int         tests_run;
   int         tests_failed;
   logic       saw_block;

   function automatic logic elig(input logic [7:0] c);
`ifdef KEY_EVENT_TRACKER_MOVE_FILTER_EN
      return (c == 8'h04) || (c == 8'h07) || (c == 8'h16) || (c == 8'h1A);
`else
      return (c != 8'h00);
`endif
   endfunction

   function automatic void model_apply(input logic [7:0] c, input logic p);
      int pos;
      if (c == 8'h00) return;
      pos = -1;
      foreach (held[i]) if (held[i] == c && pos < 0) pos = i;
      if (p) begin
         if (pos >= 0) held.delete(pos);
         held.push_front(c);
         if (held.size() > 4) begin
            void'(held.pop_back());
            model_ov = 1'b1;
         end
      end else if (pos >= 0) begin
         held.delete(pos);
      end
   endfunction

   function automatic logic [7:0] model_kc();
      foreach (held[i]) if (elig(held[i])) return held[i];
      return 8'h00;
   endfunction

   // Acceptance snoop and scoreboard pop; outputs sampled 1 unit after the edge.
   always @(posedge frame_clk) begin
      exp_t e;
      cyc = cyc + 1;
      if (!Reset && ev_valid && ev_ready) begin
         model_apply(ev_code, ev_press);
         e.due    = (cyc + 3 > last_due + 3) ? cyc + 3 : last_due + 3;
         last_due = e.due;
         e.kc     = model_kc();
         e.hc     = 3'(held.size());
         e.ov     = model_ov;
         sb.push_back(e);
      end
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         tests_run = tests_run + 3;
         if (keycode !== e.kc) begin
            tests_failed++;
            $display("FAIL sb_keycode @%0d: got %h expected %h", cyc, keycode, e.kc);
         end
         if (held_count !== e.hc) begin
            tests_failed++;
            $display("FAIL sb_held_count @%0d: got %0d expected %0d", cyc, held_count, e.hc);
         end
         if (overflow !== e.ov) begin
            tests_failed++;
            $display("FAIL sb_overflow @%0d: got %b expected %b", cyc, overflow, e.ov);
         end
      end
   end

   task automatic clear_model();
      sb.delete();
      held.delete();
      model_ov = 1'b0;
      last_due = 0;
   endtask

   task automatic do_reset();
      @(negedge frame_clk);
      ev_valid = 1'b0;
      Reset    = 1'b1;
      clear_model();
      repeat (2) @(negedge frame_clk);
      Reset = 1'b0;
      @(negedge frame_clk);
   endtask

   // Offer one event and hold it until accepted; leaves ev_valid high.
   task automatic send(input logic [7:0] c, input logic p);
      int n;
      ev_valid = 1'b1;
      ev_code  = c;
      ev_press = p;
      n = 0;
      while (!ev_ready && n < 50) begin
         saw_block = 1'b1;
         @(negedge frame_clk);
         n++;
      end
      if (!ev_ready) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout: ev_ready got %b expected 1", ev_ready);
      end
      @(posedge frame_clk);
      @(negedge frame_clk);
   endtask

   task automatic idle();
      ev_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge frame_clk);
         n++;
      end
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
      end
      @(negedge frame_clk);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      clear_model();
      #3;
      tests_run = tests_run + 5;
      if (keycode !== 8'h00) begin
         tests_failed++; $display("FAIL reset_keycode: got %h expected 00", keycode);
      end
      if (held_count !== 3'd0) begin
         tests_failed++; $display("FAIL reset_held: got %0d expected 0", held_count);
      end
      if (overflow !== 1'b0) begin
         tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow);
      end
      if (busy !== 1'b0) begin
         tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy);
      end
      if (ev_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_ready: got %b expected 1", ev_ready);
      end
      do_reset();
   endtask

   task automatic test_latency();
      do_reset();
      send(8'h1A, 1'b1);
      idle();
      // Now just past edge N; keycode must hold 00 through N+2.
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if (keycode !== 8'h00) begin
            tests_failed++;
            $display("FAIL latency_early_%0d: got %h expected 00", k, keycode);
         end
         if (k < 2) @(negedge frame_clk);
      end
      @(negedge frame_clk);
      tests_run = tests_run + 2;
      if (keycode !== 8'h1A) begin
         tests_failed++; $display("FAIL latency_n3_keycode: got %h expected 1a", keycode);
      end
      if (held_count !== 3'd1) begin
         tests_failed++; $display("FAIL latency_n3_held: got %0d expected 1", held_count);
      end
      wait_drain();
   endtask

   task automatic test_press_release();
      do_reset();
      send(8'h04, 1'b1); idle(); wait_drain();
      send(8'h07, 1'b1); idle(); wait_drain();
      send(8'h07, 1'b0); idle(); wait_drain();
      send(8'h00, 1'b1); idle(); wait_drain();
      tests_run = tests_run + 2;
      if (keycode !== 8'h04) begin
         tests_failed++; $display("FAIL press_release_keycode: got %h expected 04", keycode);
      end
      if (held_count !== 3'd1) begin
         tests_failed++; $display("FAIL press_release_held: got %0d expected 1", held_count);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] codes[5] = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C};
      do_reset();
      foreach (codes[i]) begin
         send(codes[i], 1'b1); idle(); wait_drain();
      end
      send(8'h04, 1'b0); idle(); wait_drain();
      send(8'h16, 1'b1); idle(); wait_drain();
      tests_run = tests_run + 2;
      if (overflow !== 1'b1) begin
         tests_failed++; $display("FAIL overflow_sticky: got %b expected 1", overflow);
      end
      if (held_count !== 3'd4) begin
         tests_failed++; $display("FAIL overflow_held: got %0d expected 4", held_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] codes[8] = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h16, 8'h07, 8'h07, 8'h2C};
      logic       press[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      saw_block = 1'b0;
      foreach (codes[i]) send(codes[i], press[i]);
      idle();
      wait_drain();
      tests_run++;
      if (saw_block !== 1'b1) begin
         tests_failed++; $display("FAIL b2b_backpressure: ready_dropped got %b expected 1", saw_block);
      end
   endtask

   task automatic test_filter();
      logic [7:0] exp_kc;
`ifdef KEY_EVENT_TRACKER_MOVE_FILTER_EN
      exp_kc = 8'h04;
`else
      exp_kc = 8'h2C;
`endif
      do_reset();
      send(8'h04, 1'b1);
      send(8'h2C, 1'b1);
      idle();
      wait_drain();
      tests_run++;
      if (keycode !== exp_kc) begin
         tests_failed++; $display("FAIL filter_keycode: got %h expected %h", keycode, exp_kc);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(8'h1A, 1'b1); idle(); wait_drain();
      send(8'h04, 1'b1);
      send(8'h07, 1'b1);
      send(8'h16, 1'b1);
      idle();
      // First event is in APPLY, two more queued.
      Reset = 1'b1;
      clear_model();
      #1;
      tests_run = tests_run + 5;
      if (keycode !== 8'h00) begin
         tests_failed++; $display("FAIL midrst_keycode: got %h expected 00", keycode);
      end
      if (held_count !== 3'd0) begin
         tests_failed++; $display("FAIL midrst_held: got %0d expected 0", held_count);
      end
      if (overflow !== 1'b0) begin
         tests_failed++; $display("FAIL midrst_overflow: got %b expected 0", overflow);
      end
      if (busy !== 1'b0) begin
         tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy);
      end
      if (ev_ready !== 1'b1) begin
         tests_failed++; $display("FAIL midrst_ready: got %b expected 1", ev_ready);
      end
      repeat (2) @(negedge frame_clk);
      Reset = 1'b0;
      repeat (15) @(negedge frame_clk);
      tests_run = tests_run + 3;
      if (keycode !== 8'h00) begin
         tests_failed++; $display("FAIL midrst_after_keycode: got %h expected 00", keycode);
      end
      if (held_count !== 3'd0) begin
         tests_failed++; $display("FAIL midrst_after_held: got %0d expected 0", held_count);
      end
      if (busy !== 1'b0) begin
         tests_failed++; $display("FAIL midrst_after_busy: got %b expected 0", busy);
      end
   endtask

   initial begin
      cyc          = 0;
      tests_run    = 0;
      tests_failed = 0;
      saw_block    = 1'b0;
      model_ov     = 1'b0;
      last_due     = 0;
      test_reset();
      test_latency();
      test_press_release();
      test_overflow();
      test_back_to_back();
      test_filter();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/key_event_tracker.md
KEY_EVENT_TRACKER -- requirements
Module: key_event_tracker

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, event-queue depth (power of two, >=2).
REQ-002 The block SHALL have parameter SLOTS, default 4, held-key table size.
REQ-003 The block SHALL have port frame_clk  input  1  clock; all state on rising edge.
REQ-004 The block SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port ev_valid  input  1  key event offered.
REQ-006 The block SHALL have port ev_ready  output  1  event queue can accept.
REQ-007 The block SHALL have port ev_code  input  8  HID usage code of event.
REQ-008 The block SHALL have port ev_press  input  1  1 = press, 0 = release.
REQ-009 The block SHALL have port keycode  output  8  registered current-direction key for the movement logic; 8'h00 = none.
REQ-010 The block SHALL have port held_count  output  3  number of valid held-table slots.
REQ-011 The block SHALL have port overflow  output  1  sticky; a held key was evicted.
REQ-012 The block SHALL have port busy  output  1  FSM not IDLE or queue non-empty.

Function
REQ-013 An event SHALL be accepted on an edge where ev_valid && ev_ready; ev_ready = !queue_full, combinational from queue state only.
REQ-014 When the queue is full, ev_ready SHALL be 0 even if a pop occurs in the same cycle; there is no push-through-when-full.
REQ-015 The queue SHALL be FIFO-ordered; pointers wrap modulo FIFO_DEPTH; count SHALL NOT exceed FIFO_DEPTH.
REQ-016 The FSM SHALL have states IDLE, SCAN, APPLY; IDLE->SCAN pops one event when the queue is non-empty; SCAN->APPLY unconditionally; APPLY->IDLE unconditionally.
REQ-017 SCAN SHALL compare the latched event code against all valid slots in parallel and register hit and hit_index.
REQ-018 APPLY, press, no hit: shift slots down by one and insert the code at slot 0; if all SLOTS were valid, drop the oldest slot and set overflow.
REQ-019 APPLY, press, hit: move the matching code to slot 0, preserving the relative order of the others.
REQ-020 APPLY, release, hit: remove the slot and compact younger-to-older with no gaps; release with no hit SHALL be a no-op.
REQ-021 An event with ev_code 8'h00 SHALL be accepted and consumed with no table change.
REQ-022 keycode and held_count SHALL update on the APPLY edge; latency from the accepting edge N to the updated keycode SHALL be edge N+3; throughput one event per 3 cycles.
REQ-023 keycode SHALL equal the code in the lowest-index (most recent) eligible valid slot, else 8'h00.
REQ-024 Slot 0 SHALL always hold the most recently pressed still-held key.

Reset
REQ-025 Reset asserted SHALL immediately force: queue empty, all slots invalid, FSM IDLE, keycode 8'h00, held_count 0, overflow 0, busy 0, ev_ready 1.
REQ-026 Reset asserted mid-event (SCAN/APPLY) SHALL discard that event and all queued events.

Configuration
REQ-027 With KEY_EVENT_TRACKER_MOVE_FILTER_EN defined, only KEY_A 8'h04, KEY_D 8'h07, KEY_S 8'h16, KEY_W 8'h1A SHALL be eligible for keycode; the table still tracks all codes.
REQ-028 Without KEY_EVENT_TRACKER_MOVE_FILTER_EN, every non-zero code SHALL be eligible.

Structure
REQ-029 Package key_pkg SHALL hold KEY_A/KEY_D/KEY_S/KEY_W constants, the FSM state enum typedef, and the slot struct typedef (valid, code[7:0]).
REQ-030 The event queue SHALL be a sub-module key_event_fifo (synchronous, push/pop/full/empty); table and FSM stay in key_event_tracker.

Verification
REQ-031 Reset, then press 8'h1A at edge N -> keycode 8'h00 through edge N+2, 8'h1A after N+3, held_count 1.
REQ-032 Press 04, press 07, release 07 -> keycode 04, 07, 04 in sequence; held_count 1, 2, 1.
REQ-033 Press 04,07,16,1A,2C (SLOTS=4) -> 04 evicted, overflow=1 and sticky; release 04 is a no-op; held_count stays 4.
REQ-034 Hold ev_valid high for 8 back-to-back events -> ev_ready drops when 4 are queued; all 8 events are applied in order; no loss or duplication.
REQ-035 With filter: press 04 then 2C -> keycode stays 04; without filter -> keycode 2C.
REQ-036 Assert Reset during APPLY with 2 queued events -> all outputs take reset values the same cycle; no queued event is applied after release.
